// File: rtl/bus_port_endpoint.sv
// bus_port_endpoint
//   Device end of one arbiter port. Host packets are queued in a TX FIFO and
//   offered to the bus through the pndng/pop handshake. Bus packets arriving
//   on push are filtered by destination ID and queued in an RX FIFO for the
//   host.
//
// Ports
//   clk, reset          : single clock; synchronous active-low reset
//   pndng, D_pop, pop   : bus side of the TX FIFO (first-word fall-through)
//   push, D_push        : bus side of the RX filter
//   tx_valid/tx_data/tx_ready : host write into the TX FIFO
//   rx_valid/rx_data/rx_ready : host read from the RX FIFO (fall-through)
//   tx_count, rx_count  : FIFO occupancies
//   rx_overflow         : sticky, candidate dropped because RX was full
//   tx_underflow        : sticky, pop seen with TX empty
//   misroute_cnt        : saturating count of foreign-ID packets dropped
//
// Handshake: a transfer happens on a rising edge where the offering side's
// valid (tx_valid / pndng / rx_valid) and the taking side's ready
// (tx_ready / pop / rx_ready) are both high. Full and empty are judged from
// the occupancy registered before the edge, so a read never frees space for
// a same-cycle write and a write never feeds a same-cycle read.
module bus_port_endpoint #(
   parameter int          PCKG_SZ   = 16,
   parameter int          DEPTH     = 8,
   parameter logic [7:0]  MY_ID     = 8'h00,
   parameter logic [7:0]  BROADCAST = 8'hFF,
   localparam int         PW        = $clog2(DEPTH),
   localparam int         CW        = PW + 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               pndng,
   output logic [PCKG_SZ-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [PCKG_SZ-1:0] D_push,
   input  logic               tx_valid,
   input  logic [PCKG_SZ-1:0] tx_data,
   output logic               tx_ready,
   output logic               rx_valid,
   output logic [PCKG_SZ-1:0] rx_data,
   input  logic               rx_ready,
   output logic [CW-1:0]      tx_count,
   output logic [CW-1:0]      rx_count,
   output logic               rx_overflow,
   output logic               tx_underflow,
   output logic [7:0]         misroute_cnt
);

   logic [PCKG_SZ-1:0] tx_mem_q [DEPTH];
   logic [PCKG_SZ-1:0] rx_mem_q [DEPTH];

   logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic          rx_overflow_q, rx_overflow_d;
   logic          tx_underflow_q, tx_underflow_d;
   logic [7:0]    misroute_cnt_q, misroute_cnt_d;

   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic       tx_wr, tx_rd, rx_wr, rx_rd;
   logic [7:0] rx_id;
   logic       rx_match;

   always_comb begin
      tx_full  = (tx_count_q == CW'(DEPTH));
      tx_empty = (tx_count_q == '0);
      rx_full  = (rx_count_q == CW'(DEPTH));
      rx_empty = (rx_count_q == '0);

      tx_wr = tx_valid && !tx_full;
      tx_rd = pop && !tx_empty;

      rx_id    = D_push[PCKG_SZ-1 -: 8];
      rx_match = (rx_id == MY_ID) || (rx_id == BROADCAST);
      rx_wr    = push && rx_match && !rx_full;
      rx_rd    = rx_ready && !rx_empty;

      // DEPTH is a power of two, so plain pointer overflow gives the wrap.
      tx_wr_ptr_d = tx_wr ? tx_wr_ptr_q + PW'(1) : tx_wr_ptr_q;
      tx_rd_ptr_d = tx_rd ? tx_rd_ptr_q + PW'(1) : tx_rd_ptr_q;
      rx_wr_ptr_d = rx_wr ? rx_wr_ptr_q + PW'(1) : rx_wr_ptr_q;
      rx_rd_ptr_d = rx_rd ? rx_rd_ptr_q + PW'(1) : rx_rd_ptr_q;

      tx_count_d = tx_count_q;
      if (tx_wr && !tx_rd) tx_count_d = tx_count_q + CW'(1);
      if (!tx_wr && tx_rd) tx_count_d = tx_count_q - CW'(1);

      rx_count_d = rx_count_q;
      if (rx_wr && !rx_rd) rx_count_d = rx_count_q + CW'(1);
      if (!rx_wr && rx_rd) rx_count_d = rx_count_q - CW'(1);

      rx_overflow_d  = rx_overflow_q  | (push && rx_match && rx_full);
      tx_underflow_d = tx_underflow_q | (pop && tx_empty);

      misroute_cnt_d = misroute_cnt_q;
      if (push && !rx_match && (misroute_cnt_q != 8'hFF))
         misroute_cnt_d = misroute_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_wr_ptr_q    <= '0;
         tx_rd_ptr_q    <= '0;
         rx_wr_ptr_q    <= '0;
         rx_rd_ptr_q    <= '0;
         tx_count_q     <= '0;
         rx_count_q     <= '0;
         rx_overflow_q  <= 1'b0;
         tx_underflow_q <= 1'b0;
         misroute_cnt_q <= '0;
      end else begin
         tx_wr_ptr_q    <= tx_wr_ptr_d;
         tx_rd_ptr_q    <= tx_rd_ptr_d;
         rx_wr_ptr_q    <= rx_wr_ptr_d;
         rx_rd_ptr_q    <= rx_rd_ptr_d;
         tx_count_q     <= tx_count_d;
         rx_count_q     <= rx_count_d;
         rx_overflow_q  <= rx_overflow_d;
         tx_underflow_q <= tx_underflow_d;
         misroute_cnt_q <= misroute_cnt_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid. Writes are
   // still blocked in the reset cycle so a strobe there leaves no trace.
   always_ff @(posedge clk) begin
      if (reset && tx_wr) tx_mem_q[tx_wr_ptr_q] <= tx_data;
      if (reset && rx_wr) rx_mem_q[rx_wr_ptr_q] <= D_push;
   end

   assign pndng        = !tx_empty;
   assign tx_ready     = !tx_full;
   assign D_pop        = tx_mem_q[tx_rd_ptr_q];
   assign rx_valid     = !rx_empty;
   assign rx_data      = rx_mem_q[rx_rd_ptr_q];
   assign tx_count     = tx_count_q;
   assign rx_count     = rx_count_q;
   assign rx_overflow  = rx_overflow_q;
   assign tx_underflow = tx_underflow_q;
   assign misroute_cnt = misroute_cnt_q;

endmodule

// File: tb/tb_bus_port_endpoint.sv
module tb_bus_port_endpoint;
  localparam int W = 16;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [7:0] MY_ID = 8'h02;
  localparam logic [7:0] BCAST = 8'hFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pndng, pop, push, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [W-1:0] D_pop, D_push, tx_data, rx_data;
  logic [CW-1:0] tx_count, rx_count;
  logic rx_overflow, tx_underflow;
  logic [7:0] misroute_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bus_port_endpoint #(
    .PCKG_SZ(W), .DEPTH(DEPTH), .MY_ID(MY_ID), .BROADCAST(BCAST)
  ) dut (
    .clk(clk), .reset(reset),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .tx_underflow(tx_underflow),
    .misroute_cnt(misroute_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Each FIFO is modelled as a queue of expected packets. Entries are pushed
  // when the stimulus presented at an edge is accepted and popped when the
  // DUT hands the head out.
  logic [W-1:0] tx_exp_q[$];
  logic [W-1:0] rx_exp_q[$];
  bit m_rx_ovf, m_tx_unf;
  int m_misroute;

  always @(negedge clk) begin
    bit tx_take, tx_give, rx_take, rx_give, cand;
    if (armed) begin
      check("pndng", pndng, tx_exp_q.size() != 0);
      check("tx_ready", tx_ready, tx_exp_q.size() != DEPTH);
      check("tx_count", tx_count, tx_exp_q.size());
      check("rx_valid", rx_valid, rx_exp_q.size() != 0);
      check("rx_count", rx_count, rx_exp_q.size());
      check("rx_overflow", rx_overflow, m_rx_ovf);
      check("tx_underflow", tx_underflow, m_tx_unf);
      check("misroute_cnt", misroute_cnt, m_misroute);
      if (tx_exp_q.size() != 0) check("D_pop", D_pop, tx_exp_q[0]);
      if (rx_exp_q.size() != 0) check("rx_data", rx_data, rx_exp_q[0]);
    end
    // Advance the model with the inputs that the coming edge will sample.
    if (!reset) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      m_rx_ovf = 0;
      m_tx_unf = 0;
      m_misroute = 0;
    end else begin
      tx_give = pop && tx_exp_q.size() != 0;
      tx_take = tx_valid && tx_exp_q.size() != DEPTH;
      if (pop && tx_exp_q.size() == 0) m_tx_unf = 1;
      cand = push && (D_push[W-1 -: 8] == MY_ID || D_push[W-1 -: 8] == BCAST);
      if (push && !cand && m_misroute < 255) m_misroute++;
      rx_give = rx_ready && rx_exp_q.size() != 0;
      rx_take = cand && rx_exp_q.size() != DEPTH;
      if (cand && rx_exp_q.size() == DEPTH) m_rx_ovf = 1;
      if (tx_give) void'(tx_exp_q.pop_front());
      if (tx_take) tx_exp_q.push_back(tx_data);
      if (rx_give) void'(rx_exp_q.pop_front());
      if (rx_take) rx_exp_q.push_back(D_push);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    pop = 0; push = 0; tx_valid = 0; rx_ready = 0;
    D_push = '0; tx_data = '0;
  endtask

  task automatic host_write(input logic [W-1:0] d);
    tx_valid = 1; tx_data = d;
    step();
    tx_valid = 0;
  endtask

  task automatic bus_push(input logic [W-1:0] d);
    push = 1; D_push = d;
    step();
    push = 0;
  endtask

  task automatic pulse_reset();
    reset = 0;
    step();
    reset = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    reset = 0;
    step(2);
    reset = 1;
    armed = 1;
    check("rst_pndng", pndng, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_counts", {tx_count, rx_count}, 0);
    check("rst_flags", {rx_overflow, tx_underflow, misroute_cnt}, 0);

    // TX ordering, full refusal, pointer wrap (two rounds)
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= DEPTH; i++) host_write(16'h0300 + 16'(i));
      host_write(16'h0309);
      check("tx_full_count", tx_count, DEPTH);
      check("tx_full_ready", tx_ready, 0);
      pop = 1;
      step(DEPTH);
      pop = 0;
      check("tx_drained", pndng, 0);
    end

    // RX filter
    bus_push(16'h02AA);
    check("rx_accept_own", rx_data, 16'h02AA);
    bus_push(16'hFF55);
    bus_push(16'h0777);
    check("rx_misroute", misroute_cnt, 1);
    check("rx_count_after_filter", rx_count, 2);
    rx_ready = 1;
    step(2);
    rx_ready = 0;

    // RX overflow with a same-cycle host read
    for (int i = 0; i < DEPTH; i++) bus_push({MY_ID, 8'($urandom_range(0, 255))});
    push = 1; D_push = 16'h02C3; rx_ready = 1;
    step();
    push = 0; rx_ready = 0;
    check("rx_ovf_count", rx_count, DEPTH - 1);
    check("rx_ovf_flag", rx_overflow, 1);
    rx_ready = 1;
    step(DEPTH);
    rx_ready = 0;

    // TX underflow
    pop = 1;
    step();
    pop = 0;
    check("tx_unf_flag", tx_underflow, 1);
    check("tx_unf_count", tx_count, 0);

    // Simultaneous write and read at count 3
    for (int i = 1; i <= 3; i++) host_write(16'h0310 + 16'(i));
    tx_valid = 1; tx_data = 16'h0314; pop = 1;
    step();
    tx_valid = 0; pop = 0;
    check("tx_simul_count", tx_count, 3);
    pop = 1;
    step(3);
    pop = 0;

    // Mid-operation reset
    pulse_reset();
    for (int i = 0; i < 4; i++) host_write(16'h0400 + 16'(i));
    for (int i = 0; i < 3; i++) bus_push(16'h0501);
    for (int i = 0; i < 5; i++) bus_push(16'h0260 + 16'(i));
    check("pre_rst_counts", {tx_count, rx_count}, {4'(4), 4'(5)});
    check("pre_rst_misroute", misroute_cnt, 3);
    reset = 0; push = 1; D_push = 16'h02EE; pop = 1; tx_valid = 1; tx_data = 16'h0499;
    step();
    reset = 1;
    idle_inputs();
    check("mid_rst_counts", {tx_count, rx_count}, 0);
    check("mid_rst_flags", {rx_overflow, tx_underflow, misroute_cnt}, 0);
    step();
    check("mid_rst_push_dropped", rx_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int sel;
      tx_valid = ($urandom_range(0, 99) < 55);
      tx_data  = W'($urandom);
      pop      = ($urandom_range(0, 99) < 45);
      rx_ready = ($urandom_range(0, 99) < 45);
      push     = ($urandom_range(0, 99) < 55);
      sel = $urandom_range(0, 2);
      D_push   = W'($urandom);
      if (sel == 0) D_push[W-1 -: 8] = MY_ID;
      else if (sel == 1) D_push[W-1 -: 8] = BCAST;
      reset    = ($urandom_range(0, 999) != 0);
      step();
    end
    reset = 1;
    idle_inputs();
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_port_endpoint.md
# bus_port_endpoint

Device-side endpoint for one port of the `bs_gnrtr_n_rbtr` bus generator/arbiter. It is the device end of that port's `pndng`/`pop`/`push` handshake: it holds outgoing packets in a TX FIFO and presents them to the bus, and it filters incoming packets by destination ID into an RX FIFO for the host. One instance sits on each of the `drvrs` bus ports, replacing the behavioural FIFO model the driver currently emulates.

## Interface
Parameters:
- `PCKG_SZ`, 16: packet width in bits. Bits `[PCKG_SZ-1:PCKG_SZ-8]` hold the destination ID; the rest is payload.
- `DEPTH`, 8: entries per FIFO. Must be a power of 2 and ≥2.
- `MY_ID`, 8'h00: this port's bus ID.
- `BROADCAST`, 8'hFF: broadcast ID, accepted by every port.

Ports (`CW = $clog2(DEPTH)+1`):
- `clk`  in  1  Single clock; everything updates on the rising edge.
- `reset`  in  1  Synchronous, active-low reset. Sampled on the `clk` rising edge; 0 resets.
- `pndng`  out  1  To the bus: TX FIFO is non-empty.
- `D_pop`  out  PCKG_SZ  To the bus: head of the TX FIFO (first-word fall-through).
- `pop`  in  1  From the bus: consume the TX head.
- `push`  in  1  From the bus: `D_push` is valid this cycle.
- `D_push`  in  PCKG_SZ  From the bus: incoming packet.
- `tx_valid`  in  1  Host offers `tx_data`.
- `tx_data`  in  PCKG_SZ  Host packet to send.
- `tx_ready`  out  1  TX FIFO not full.
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_data`  out  PCKG_SZ  RX FIFO head (first-word fall-through).
- `rx_ready`  in  1  Host consumes the RX head.
- `tx_count`  out  CW  TX FIFO occupancy.
- `rx_count`  out  CW  RX FIFO occupancy.
- `rx_overflow`  out  1  Sticky: a packet was dropped because the RX FIFO was full.
- `tx_underflow`  out  1  Sticky: `pop` arrived while the TX FIFO was empty.
- `misroute_cnt`  out  8  Saturating count of packets dropped for a foreign destination ID.

## Operation
- Both FIFOs are circular buffers. Each has read/write pointers of width `$clog2(DEPTH)` that wrap modulo `DEPTH`, plus a `CW`-bit occupancy counter.
- Full/empty flags come only from the counter value registered at the start of the cycle.
- TX path:
  - A write happens when `tx_valid && tx_ready`.
  - A read happens when `pop && pndng`.
  - `pndng = (tx_count != 0)`, `tx_ready = (tx_count != DEPTH)`, `D_pop = mem[rd_ptr]`.
- `pop` while `tx_count == 0`: no state change; `tx_underflow` is set.
- RX filter: on `push`, let `id = D_push[PCKG_SZ-1:PCKG_SZ-8]`.
  - If `id == MY_ID` or `id == BROADCAST`, the packet is a candidate.
  - Otherwise it is dropped and `misroute_cnt` increments, saturating at 255.
- A candidate is written when `rx_count != DEPTH`. Otherwise it is dropped and `rx_overflow` is set.
- RX read: on `rx_valid && rx_ready`. `rx_ready` while empty is ignored, with no flag.
- The full packet, ID included, is stored in both directions.
- Simultaneous read and write on the same FIFO, when neither is blocked:
  - both pointers advance;
  - the count is unchanged.
- At full, a same-cycle read does not make room for a same-cycle write. The write is refused (TX: `tx_ready` = 0; RX: dropped with overflow), because full is evaluated before the edge.
- At empty, a same-cycle write does not satisfy a same-cycle read. Write-through bypass is not implemented.
- Reset (`reset` = 0 at a rising edge), whether idle or mid-operation:
  - pointers, counts, `rx_overflow`, `tx_underflow` and `misroute_cnt` go to 0;
  - FIFO contents are discarded;
  - any `pop`, `push` or host strobe in the reset cycle is ignored.
- Sticky flags and `misroute_cnt` clear only on reset.

## Timing
- Reset values:
  - `pndng` = 0, `tx_ready` = 1, `rx_valid` = 0;
  - `tx_count` = 0, `rx_count` = 0;
  - `rx_overflow` = 0, `tx_underflow` = 0, `misroute_cnt` = 0;
  - `D_pop`/`rx_data` don't-care.
- Host write to `pndng`:
  - A host write accepted at edge N raises `pndng` at N (visible in cycle N+1), with `D_pop` valid in that same cycle.
  - Latency is 1 cycle.
- `pop` sampled at edge N: the next head, or `pndng` = 0, appears after N.
  - The bus may hold `pop` high on consecutive cycles to drain one entry per cycle.
- `push` at edge N: `rx_valid`/`rx_data` are valid after N. Latency is 1 cycle.
- All outputs are registered or are decoded directly from registered state. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: hold `reset` = 0 for 2 cycles, release.
  - Expect `pndng` = 0, `tx_ready` = 1, `rx_valid` = 0, both counts 0, all flags 0.
- TX ordering and wrap, `DEPTH` = 8, `MY_ID` = 2:
  - Write 8 packets 16'h0301..16'h0308. Expect `tx_ready` = 0 and `tx_count` = 8.
  - A 9th write is refused.
  - Pulse `pop` 8 times. Expect `D_pop` to step through 0301..0308, then `pndng` = 0.
  - Repeat once to exercise pointer wrap.
- RX filter:
  - Push 16'h02AA. Expect accept, `rx_data` = 02AA.
  - Push 16'hFF55. Expect accept (broadcast).
  - Push 16'h0777. Expect drop, `misroute_cnt` = 1, `rx_count` = 2.
- RX overflow and simultaneity:
  - Fill RX with 8 packets.
  - Push with `rx_ready` = 1 in the same cycle. Expect the packet dropped, `rx_overflow` = 1, `rx_count` = 7.
- Underflow and boundary:
  - `pop` with TX empty: expect `tx_underflow` = 1 and count stays 0.
  - Same-cycle `tx_valid` and `pop` with `tx_count` = 3: expect the count stays 3 and FIFO order is preserved.
- Mid-operation reset:
  - With 4 TX and 5 RX entries and `misroute_cnt` = 3, assert `reset` for 1 cycle together with `push` and `pop`.
  - Expect all counts, flags and the counter at 0, and the pushed packet not stored.
